// File: rtl/clken_divider.sv
// clken_divider
// -------------
// Multi-channel clock-enable divider. Each channel turns the upstream tick
// (enableIn) into a one-cycle enable pulse once every D ticks. D is the
// channel's programmable divisor, and a divisor of 0 behaves as 1. All
// state changes on the falling edge of clk.
//
// Optional build macro: CLKEN_CASCADE_EN
//   undefined : every channel ticks from enableIn on its own.
//   defined   : channel 0 ticks from enableIn. Channel n>0 ticks from the
//               registered pulse of channel n-1, so the divisors multiply
//               down the chain.
//
// Parameters
//   WIDTH       width of each divisor register and down-counter
//   CHANNELS    number of enable outputs (1..16)
//   DEFAULT_DIV divisor loaded into every channel at reset
//
// Ports
//   clk        block clock (falling-edge active)
//   rst        synchronous, active-low reset
//   enableIn   upstream tick; channels advance only while it is high
//   sync       restarts every channel counter from its divisor
//   load       divisor write strobe
//   load_ch    channel addressed by the write (ignored if >= CHANNELS)
//   load_div   divisor value to write
//   enableOut  registered per-channel enable pulses
module clken_divider #(
   parameter int WIDTH       = 8,
   parameter int CHANNELS    = 4,
   parameter int DEFAULT_DIV = 50
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enableIn,
   input  logic                sync,
   input  logic                load,
   input  logic [3:0]          load_ch,
   input  logic [WIDTH-1:0]    load_div,
   output logic [CHANNELS-1:0] enableOut
);

   localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

   // Counter reload value for a divisor: effective divisor minus one.
   // A divisor of 0 counts as 1, so both 0 and 1 reload to 0.
   function automatic logic [WIDTH-1:0] reload_of(input logic [WIDTH-1:0] d);
      return (d == '0) ? '0 : d - WIDTH'(1);
   endfunction

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      logic [WIDTH-1:0] div;
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] div_next;
      logic             pulse;
      logic             tick;
      logic             hit;

`ifdef CLKEN_CASCADE_EN
      // Chained mode: each channel after the first counts the pulses of
      // its predecessor from the previous edge.
      if (n == 0) begin : g_head
         assign tick = enableIn;
      end else begin : g_tail
         assign tick = enableOut[n-1];
      end
`else
      assign tick = enableIn;
`endif

      // n is always below CHANNELS, so an out-of-range load_ch matches no
      // channel. Such a write therefore changes nothing.
      assign hit      = load && (int'(load_ch) == n);
      assign div_next = hit ? load_div : div;

      // Priority on each edge: reset, then sync, then a load to this
      // channel, then a normal tick. Sync reloads from the post-write
      // divisor, so a same-edge load takes effect immediately. The pulse
      // register is cleared by default, which keeps every pulse one cycle
      // wide.
      always_ff @(negedge clk) begin
         if (!rst) begin
            div   <= RESET_DIV;
            cnt   <= reload_of(RESET_DIV);
            pulse <= 1'b0;
         end else begin
            pulse <= 1'b0;
            div   <= div_next;
            if (sync) begin
               cnt <= reload_of(div_next);
            end else if (hit) begin
               cnt <= reload_of(load_div);
            end else if (tick) begin
               if (cnt == '0) begin
                  cnt   <= reload_of(div);
                  pulse <= 1'b1;
               end else begin
                  cnt <= cnt - WIDTH'(1);
               end
            end
         end
      end

      assign enableOut[n] = pulse;
   end

endmodule

// File: tb/tb_clken_divider.sv
// tb_clken_divider
// ----------------
// Directed bench for clken_divider with WIDTH=8, CHANNELS=4 and
// DEFAULT_DIV=50. Inputs change 1ns after each falling edge. Outputs are
// checked at the same point, after the DUT has registered that edge.
// Expected values are worked out by hand from the divisor and tick history.
module tb_clken_divider;

   localparam int WIDTH       = 8;
   localparam int CHANNELS    = 4;
   localparam int DEFAULT_DIV = 50;

   logic                clk = 1'b1;
   logic                rst;
   logic                enableIn;
   logic                sync;
   logic                load;
   logic [3:0]          load_ch;
   logic [WIDTH-1:0]    load_div;
   logic [CHANNELS-1:0] enableOut;

   int checkCount = 0;
   int errorCount = 0;

   logic [CHANNELS-1:0] seen;
   logic [CHANNELS-1:0] expOut;

   clken_divider #(
      .WIDTH      (WIDTH),
      .CHANNELS   (CHANNELS),
      .DEFAULT_DIV(DEFAULT_DIV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enableIn (enableIn),
      .sync     (sync),
      .load     (load),
      .load_ch  (load_ch),
      .load_div (load_div),
      .enableOut(enableOut)
   );

   // Free-running clock, falling edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one set of inputs, lets one falling edge consume them, then
   // settles 1ns so the registered outputs can be sampled.
   task automatic applyStimulus(input logic en, input logic sy, input logic ld,
                                input logic [3:0] ch, input logic [WIDTH-1:0] dv);
      enableIn = en;
      sync     = sy;
      load     = ld;
      load_ch  = ch;
      load_div = dv;
      @(negedge clk);
      #1;
   endtask

   // Runs 49 ticks that must stay silent, then the 50th tick, which must
   // produce the expected pulse word.
   task automatic fiftyTickPeriod(input string tag, input logic [CHANNELS-1:0] exp50);
      seen = '0;
      for (int k = 1; k < 50; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
         seen |= enableOut;
      end
      checkOutput({tag, "Quiet"}, 32'(seen), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      checkOutput({tag, "Pulse"}, 32'(enableOut), 32'(exp50));
   endtask

   initial begin
      // Reset wins over sync, load and enableIn.
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'd0);
      checkOutput("reset", 32'(enableOut), 32'h0);
      rst = 1'b1;

`ifndef CLKEN_CASCADE_EN
      // Default divisor: every channel pulses on tick 50, then every 50.
      fiftyTickPeriod("first", 4'hF);
      fiftyTickPeriod("second", 4'hF);

      // Mid-count write to channel 2. All counters sit at 39 before it.
      for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd2, 8'd3);
      checkOutput("loadEdge", 32'(enableOut), 32'h0);
      for (int k = 1; k <= 39; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
         expOut = (k % 3 == 0) ? 4'b0100 : 4'b0000;
         if (k == 39) expOut = 4'hF;
         checkOutput($sformatf("afterLoad%0d", k), 32'(enableOut), 32'(expOut));
      end

      // Idle enableIn: outputs stay low and the counters hold.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
         checkOutput($sformatf("idle%0d", k), 32'(enableOut), 32'h0);
      end

      // Out-of-range channel: no write. Channel 2 resumes its 3-cycle
      // pattern, and no other channel starts pulsing.
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd9, 8'd1);
      checkOutput("ch9Edge", 32'(enableOut), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      checkOutput("ch9A", 32'(enableOut), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      checkOutput("ch9B", 32'(enableOut), 32'h4);

      // Divisor 0 on channel 0 behaves as 1.
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd0, 8'd0);
      checkOutput("div0Edge", 32'(enableOut), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      checkOutput("div0A", 32'(enableOut), 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      checkOutput("div0B", 32'(enableOut), 32'h5);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      checkOutput("div0C", 32'(enableOut), 32'h1);

      // Divisor 1 on channel 0: a pulse on every tick.
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd0, 8'd1);
      checkOutput("div1Edge", 32'(enableOut), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      checkOutput("div1A", 32'(enableOut), 32'h5);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      checkOutput("div1B", 32'(enableOut), 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      checkOutput("div1C", 32'(enableOut), 32'h1);

      // Divisor 4 on channel 0 with enableIn toggling 1,0,1,0.
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 8'd4);
      checkOutput("div4Edge", 32'(enableOut), 32'h0);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(k[0], 1'b0, 1'b0, 4'd0, 8'd0);
         if (k[0])
            checkOutput($sformatf("toggleHi%0d", k), 32'(enableOut[0]), (k == 7) ? 32'h1 : 32'h0);
         else
            checkOutput($sformatf("toggleLo%0d", k), 32'(enableOut), 32'h0);
      end

      // Sync with a same-edge write of divisor 4 to channel 2. Channels 0
      // and 2 then pulse together every 4 ticks. Channels 1 and 3 restart
      // at 49.
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd2, 8'd4);
      checkOutput("syncEdge", 32'(enableOut), 32'h0);
      for (int k = 1; k <= 50; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
         expOut = ((k % 4 == 0) ? 4'b0101 : 4'b0000) | ((k == 50) ? 4'b1010 : 4'b0000);
         checkOutput($sformatf("afterSync%0d", k), 32'(enableOut), 32'(expOut));
      end

      // Sync on an edge where channels 0 and 2 would have pulsed.
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      checkOutput("preMask", 32'(enableOut), 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
      checkOutput("syncMask", 32'(enableOut), 32'h0);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
         checkOutput($sformatf("postMask%0d", k), 32'(enableOut), (k == 4) ? 32'h5 : 32'h0);
      end

      // Reset mid-count restores the default divisor everywhere.
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd0, 8'd1);
      checkOutput("midReset", 32'(enableOut), 32'h0);
      rst = 1'b1;
      fiftyTickPeriod("afterReset", 4'hF);
`else
      // Cascade: channel 0 has divisor 2 and channel 1 has divisor 3.
      // Channel 1 pulses once per 6 ticks.
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 8'd2);
      checkOutput("casLoad0", 32'(enableOut), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd1, 8'd3);
      checkOutput("casLoad1", 32'(enableOut), 32'h0);
      for (int k = 1; k <= 13; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
         expOut = ((k % 2 == 0) ? 4'b0001 : 4'b0000) |
                  ((k == 7 || k == 13) ? 4'b0010 : 4'b0000);
         checkOutput($sformatf("cascade%0d", k), 32'(enableOut), 32'(expOut));
      end

      // Reset mid-sequence: channel 0 returns to the 50-tick period.
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      checkOutput("casReset", 32'(enableOut), 32'h0);
      rst = 1'b1;
      fiftyTickPeriod("casAfterReset", 4'b0001);
`endif

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
